if_stage_buf: RTL and testbench

IF_STAGE_BUF -- requirements
Module: if_stage_buf

---
 rtl/if_stage_buf.sv | 146 ++++++++++++++
 tb/tb_if_stage_buf.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_buf.sv
// Instruction-fetch stage with an in-order instruction buffer and stale-response discard.
// Optional macro IF_BYPASS_EN forwards a response straight to decode when nothing older is waiting.
module if_stage_buf #(
   parameter logic [31:0] RESET_PC  = 32'hbfc00000,
   parameter logic [31:0] EX_ENTRY  = 32'hbfc00380,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        wb_ex,
   input  logic        eret_flush,
   input  logic [31:0] epc,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adel
);

   localparam int IDX_W = $clog2(BUF_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = 8;
   localparam logic [PTR_W-1:0] PTR_ONE = 1;

   logic [31:0]          pc;
   logic [PTR_W-1:0]     head, tail, fill;
   logic [31:0]          ent_pc   [BUF_DEPTH];
   logic [31:0]          ent_inst [BUF_DEPTH];
   logic                 ent_adel [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] ent_filled;
   logic [CNT_W-1:0]     out_cnt, discard_cnt, out_nxt;
   logic                 adel_stall;

   logic                 redirect, full, empty, accept, adel_enq;
   logic                 resp_live, fill_en, bypass, buf_valid, dequeue, alloc_en;
   logic [31:0]          target;
   logic [IDX_W-1:0]     head_idx, tail_idx, fill_idx;

   assign head_idx = head[IDX_W-1:0];
   assign tail_idx = tail[IDX_W-1:0];
   assign fill_idx = fill[IDX_W-1:0];

   assign redirect = ~reset & (wb_ex | eret_flush | br_taken);
   assign target   = wb_ex ? EX_ENTRY : (eret_flush ? epc : br_target);

   assign empty = (head == tail);
   assign full  = (head_idx == tail_idx) & (head[IDX_W] != tail[IDX_W]);

   assign inst_req  = ~reset & ~redirect & (pc[1:0] == 2'b00) & ~full;
   assign inst_addr = pc;
   assign accept    = inst_req & inst_addr_ok;
   // A misaligned pc produces one faulting entry and then waits for a redirect.
   assign adel_enq  = ~reset & ~redirect & (pc[1:0] != 2'b00) & ~full & ~adel_stall;
   assign alloc_en  = accept | adel_enq;

   assign resp_live = inst_data_ok & (discard_cnt == '0);
   assign out_nxt   = out_cnt + CNT_W'(accept) - CNT_W'(inst_data_ok);

`ifdef IF_BYPASS_EN
   assign bypass = resp_live & ~redirect & ~reset & ds_allowin & ~empty
                 & (fill == head) & ~adel_stall;
`else
   assign bypass = 1'b0;
`endif

   assign fill_en   = resp_live & ~redirect & ~reset & ~bypass;
   assign buf_valid = ~reset & ~empty & ent_filled[head_idx];
   assign dequeue   = fs_to_ds_valid & ds_allowin & ~redirect;

   always_comb begin
      fs_to_ds_valid = 1'b0;
      fs_pc          = '0;
      fs_inst        = '0;
      fs_adel        = 1'b0;
      if (bypass) begin
         fs_to_ds_valid = 1'b1;
         fs_pc          = ent_pc[head_idx];
         fs_inst        = inst_rdata;
      end else if (buf_valid) begin
         fs_to_ds_valid = 1'b1;
         fs_pc          = ent_pc[head_idx];
         fs_inst        = ent_inst[head_idx];
         fs_adel        = ent_adel[head_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         fill        <= '0;
         out_cnt     <= '0;
         discard_cnt <= '0;
         adel_stall  <= 1'b0;
         ent_filled  <= '0;
      end else begin
         out_cnt <= out_nxt;
         if (redirect) begin
            // Everything still in flight, including this cycle's traffic, is now stale.
            pc          <= target;
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            adel_stall  <= 1'b0;
            discard_cnt <= out_nxt;
         end else begin
            if (inst_data_ok && discard_cnt != '0)
               discard_cnt <= discard_cnt - CNT_W'(1);
            if (accept) begin
               pc                   <= pc + 32'd4;
               tail                 <= tail + PTR_ONE;
               ent_filled[tail_idx] <= 1'b0;
            end else if (adel_enq) begin
               tail                 <= tail + PTR_ONE;
               ent_filled[tail_idx] <= 1'b1;
               adel_stall           <= 1'b1;
            end
            if (fill_en)
               ent_filled[fill_idx] <= 1'b1;
            if (fill_en || bypass)
               fill <= fill + PTR_ONE;
            if (dequeue)
               head <= head + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alloc_en) begin
         ent_pc[tail_idx]   <= pc;
         ent_inst[tail_idx] <= '0;
         ent_adel[tail_idx] <= adel_enq;
      end
      if (fill_en)
         ent_inst[fill_idx] <= inst_rdata;
   end

endmodule

// File: tb/tb_if_stage_buf.sv
// Bench for if_stage_buf: startup vector table, directed corner sequences, then random traffic
// checked cycle by cycle against a queue-based model of the fetch buffer and bus.
module tb_if_stage_buf;

   localparam logic [31:0] RESET_PC = 32'hbfc00000;
   localparam logic [31:0] EX_ENTRY = 32'hbfc00380;
   localparam int          DEPTH    = 4;
`ifdef IF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, ds_allowin, br_taken, wb_ex, eret_flush;
   logic [31:0] br_target, epc;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        fs_to_ds_valid, fs_adel;
   logic [31:0] fs_pc, fs_inst;

   if_stage_buf dut (
      .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
      .br_taken(br_taken), .br_target(br_target),
      .wb_ex(wb_ex), .eret_flush(eret_flush), .epc(epc),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst), .fs_adel(fs_adel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          adel;
      bit          filled;
   } ent_t;
   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } bus_t;

   ent_t        buf_q[$];
   bus_t        bus_q[$];
   logic [31:0] m_pc = RESET_PC;
   bit          m_stall = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic        s_req, s_valid, s_adel;
   logic [31:0] s_addr, s_pc, s_inst;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
   endfunction

   // One clock cycle: drive at the falling edge, sample, compare with the model, advance the model.
   task automatic step(input bit rst_i, input bit aok, input bit dok_req, input bit allow,
                       input bit br, input logic [31:0] bt, input bit wb, input bit er,
                       input logic [31:0] ep);
      bit          dok, redir, e_req, fresh, any_filled, byp, e_valid, e_adel, deliver;
      logic [31:0] tgt, rdata, e_pc, e_inst;
      bus_t        item;
      ent_t        ne;
      @(negedge clk);
      dok   = dok_req && !rst_i && (bus_q.size() > 0);
      rdata = dok ? mem(bus_q[0].addr) : $urandom;
      reset = rst_i;  inst_addr_ok = aok;  inst_data_ok = dok;  inst_rdata = rdata;
      ds_allowin = allow;  br_taken = br;  br_target = bt;  wb_ex = wb;  eret_flush = er;  epc = ep;
      #1;
      s_req = inst_req;  s_addr = inst_addr;  s_valid = fs_to_ds_valid;
      s_pc = fs_pc;  s_inst = fs_inst;  s_adel = fs_adel;

      redir = !rst_i && (wb || er || br);
      tgt   = wb ? EX_ENTRY : (er ? ep : bt);
      e_req = !rst_i && !redir && (m_pc[1:0] == 2'b00) && (buf_q.size() < DEPTH);
      fresh = dok && !bus_q[0].stale;
      any_filled = 1'b0;
      foreach (buf_q[i]) if (buf_q[i].filled) any_filled = 1'b1;
      byp = BYP && !rst_i && fresh && !redir && allow && !any_filled && (buf_q.size() > 0);
      e_valid = 1'b0;  e_pc = '0;  e_inst = '0;  e_adel = 1'b0;
      if (!rst_i && byp) begin
         e_valid = 1'b1;  e_pc = buf_q[0].pc;  e_inst = rdata;
      end else if (!rst_i && buf_q.size() > 0 && buf_q[0].filled) begin
         e_valid = 1'b1;  e_pc = buf_q[0].pc;  e_inst = buf_q[0].inst;  e_adel = buf_q[0].adel;
      end

      chk("inst_req", 32'(s_req), 32'(e_req));
      chk("inst_addr", s_addr, m_pc);
      chk("fs_to_ds_valid", 32'(s_valid), 32'(e_valid));
      if (rst_i || e_valid) begin
         chk("fs_pc", s_pc, e_pc);
         chk("fs_inst", s_inst, e_inst);
         chk("fs_adel", 32'(s_adel), 32'(e_adel));
      end

      if (rst_i) begin
         m_pc = RESET_PC;  m_stall = 1'b0;
         buf_q.delete();  bus_q.delete();
      end else begin
         deliver = e_valid && allow && !redir;
         if (dok) begin
            item = bus_q.pop_front();
            if (!item.stale && !redir && !byp) begin
               for (int i = 0; i < buf_q.size(); i++)
                  if (!buf_q[i].filled) begin
                     buf_q[i].inst = rdata;  buf_q[i].filled = 1'b1;
                     break;
                  end
            end
         end
         if (deliver) void'(buf_q.pop_front());
         if (redir) begin
            buf_q.delete();
            foreach (bus_q[i]) bus_q[i].stale = 1'b1;
            m_pc = tgt;  m_stall = 1'b0;
         end else if (e_req && aok) begin
            bus_q.push_back('{addr: m_pc, stale: 1'b0});
            ne = '{pc: m_pc, inst: 32'h0, adel: 1'b0, filled: 1'b0};
            buf_q.push_back(ne);
            m_pc = m_pc + 32'd4;
         end else if (m_pc[1:0] != 2'b00 && buf_q.size() < DEPTH && !m_stall) begin
            ne = '{pc: m_pc, inst: 32'h0, adel: 1'b1, filled: 1'b1};
            buf_q.push_back(ne);
            m_stall = 1'b1;
         end
      end
   endtask

   task automatic idle(input bit aok, input bit dok, input bit allow);
      step(1'b0, aok, dok, allow, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] rand_tgt(input bit misalign);
      logic [31:0] t;
      t = {16'hbfc0, 16'($urandom_range(0, 16'hfffc)) & 16'hfffc};
      if (misalign) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   typedef struct {
      bit          aok;
      bit          dok;
      bit          allow;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   initial begin
      vec_t        tbl[8];
      int          lat, acc, reqs;
      bit          got;
      logic [31:0] first_pc;

      reset = 1'b1;  ds_allowin = 1'b0;  br_taken = 1'b0;  wb_ex = 1'b0;  eret_flush = 1'b0;
      br_target = '0;  epc = '0;  inst_addr_ok = 1'b0;  inst_data_ok = 1'b0;  inst_rdata = '0;

      lat = BYP ? 1 : 2;
      for (int k = 0; k < 8; k++) begin
         tbl[k].aok     = 1'b1;
         tbl[k].dok     = (k >= 1);
         tbl[k].allow   = 1'b1;
         tbl[k].e_req   = 1'b1;
         tbl[k].e_addr  = RESET_PC + 32'(4 * k);
         tbl[k].e_valid = (k >= lat);
         tbl[k].e_pc    = (k >= lat) ? RESET_PC + 32'(4 * (k - lat)) : 32'h0;
      end

      // Startup stream: addr_ok every cycle, data one cycle after each accept.
      do_reset(3);
      for (int k = 0; k < 8; k++) begin
         idle(tbl[k].aok, tbl[k].dok, tbl[k].allow);
         chk("tbl_req", 32'(s_req), 32'(tbl[k].e_req));
         chk("tbl_addr", s_addr, tbl[k].e_addr);
         chk("tbl_valid", 32'(s_valid), 32'(tbl[k].e_valid));
         if (tbl[k].e_valid) chk("tbl_pc", s_pc, tbl[k].e_pc);
      end

      // Decode stalled: the buffer takes exactly DEPTH requests and then stops asking.
      do_reset(2);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1'b1, 1'b1, 1'b0);
         if (s_req) acc++;
      end
      chk("stall_accepts", 32'(acc), 32'(DEPTH));
      chk("stall_req_low", 32'(s_req), 32'h0);
      for (int i = 0; i < 8; i++) idle(1'b1, 1'b1, 1'b1);

      // Branch with two requests in flight: both responses dropped, stream restarts at target.
      do_reset(2);
      idle(1'b1, 1'b0, 1'b1);
      idle(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc00100, 1'b0, 1'b0, 32'h0);
      got = 1'b0;  first_pc = '0;
      for (int i = 0; i < 12; i++) begin
         idle(1'b1, 1'b1, 1'b1);
         if (s_valid && !got) begin first_pc = s_pc;  got = 1'b1; end
      end
      chk("br_first_pc", first_pc, 32'hbfc00100);

      // Exception wins over a simultaneous branch.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hbfc00100, 1'b1, 1'b0, 32'h0);
      idle(1'b0, 1'b0, 1'b1);
      chk("ex_addr", s_addr, EX_ENTRY);
      chk("ex_req", 32'(s_req), 32'h1);

      // ERET to a misaligned address: one faulting entry, then silence until redirected.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hbfc00022);
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 1'b0);
      chk("adel_valid", 32'(s_valid), 32'h1);
      chk("adel_flag", 32'(s_adel), 32'h1);
      chk("adel_inst", s_inst, 32'h0);
      chk("adel_pc", s_pc, 32'hbfc00022);
      chk("adel_req", 32'(s_req), 32'h0);
      idle(1'b1, 1'b1, 1'b1);
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b1, 1'b1, 1'b1);
         if (s_req || s_valid) reqs++;
      end
      chk("adel_quiet", 32'(reqs), 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hbfc00200, 1'b0, 1'b0, 32'h0);
      idle(1'b1, 1'b1, 1'b1);
      chk("resume_addr", s_addr, 32'hbfc00200);
      chk("resume_req", 32'(s_req), 32'h1);

      // Random traffic with occasional resets and redirects.
      for (int i = 0; i < 2500; i++) begin
         bit r, b, w, e;
         r = ($urandom_range(0, 299) == 0);
         b = ($urandom_range(0, 24) == 0);
         w = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 79) == 0);
         step(r, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 7), b, rand_tgt($urandom_range(0, 7) == 0),
              w, e, rand_tgt($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
